sr_mdu_issue: RTL
=================

# sr_mdu_issue

Issue/stall controller between the single-cycle core's decode stage and the multiply/divide unit. It accepts an MDU instruction from decode, freezes the core, launches one operation into the MDU, and waits for the result. It then emits a one-cycle register-file write and releases the core. It also owns flush handling and an optional hang watchdog.

## Interface
Parameters:
- MUL_LATENCY, default 2: MDU multiply latency in cycles; used only for the watchdog limit.
- RD_W, default 5: destination register index width.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous, active-low reset.
- req_vld, in, 1: decode holds an MDU instruction; stays high while stall is high.
- req_op, in, 3: MDU opcode; 3'b000 = MUL, all other values are unsupported.
- req_rd, in, RD_W: destination register.
- req_a, in, 32: operand A.
- req_b, in, 32: operand B.
- flush, in, 1: pipeline flush; aborts any operation in progress.
- stall, out, 1: freezes the core's PC and decode.
- mdu_srcA, out, 32: operand A to the MDU.
- mdu_srcB, out, 32: operand B to the MDU.
- mdu_op, out, 3: opcode to the MDU.
- mdu_src_vld, out, 1: one-cycle launch pulse to the MDU.
- mdu_src_clear, out, 1: MDU pipeline clear.
- mdu_result, in, 32: MDU result.
- mdu_result_vld, in, 1: MDU result valid.
- wb_we, out, 1: register-file write strobe.
- wb_rd, out, RD_W: write-back destination register.
- wb_data, out, 32: write-back data.
- err, out, 1: sticky watchdog error flag.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: operation launched, waiting for the MDU result.
  - DONE: one-cycle write-back.
- Reset:
  - State is IDLE.
  - All registered outputs are 0: mdu_srcA, mdu_srcB, mdu_op, mdu_src_vld, wb_rd, wb_data, err.
- IDLE with req_vld=1 and req_op=MUL:
  - Register req_a, req_b, req_op and req_rd.
  - Next state is WAIT.
  - mdu_src_vld=1 during the first WAIT cycle only.
- IDLE with req_vld=1 and an unsupported op:
  - No MDU launch.
  - Next state is DONE with wb_data=0.
- WAIT:
  - mdu_srcA, mdu_srcB and mdu_op are held stable for the whole state.
  - mdu_result_vld is sampled every cycle, including the launch cycle.
  - On mdu_result_vld=1: capture mdu_result into wb_data, next state is DONE.
- DONE:
  - wb_we=1 and stall=0, so the core advances at the end of this cycle.
  - Next state is IDLE unconditionally.
  - req_vld is not re-examined in DONE, because it still reflects the retiring instruction.
- stall is combinational: (IDLE & req_vld & ~flush) | WAIT.
- Flush, allowed in any state:
  - mdu_src_clear=1 in the same cycle (combinational).
  - Next state is IDLE; registered mdu_src_vld is also cleared.
  - wb_we = DONE & ~flush.
  - flush has priority over a simultaneous mdu_result_vld, which is discarded.
- An mdu_result_vld seen in IDLE or DONE is ignored.
- Assertion of reset_n=0 mid-WAIT forces IDLE immediately; no write-back occurs.

## Timing
- Request sampled in IDLE at cycle T: stall=1 from T.
- T+1: WAIT, mdu_src_vld=1.
- With MDU latency L, mdu_result_vld arrives at T+1+L and DONE is at T+2+L.
- The core stalls for L+2 cycles; the total instruction time is L+3 cycles.
- With L=2: result at T+3, wb_we at T+4.
- Unsupported op: DONE at T+1, a single stall cycle.
- Back-to-back MDU instructions: the next request is sampled at T+3+L at the earliest.

## Configuration
- SR_MDU_WATCHDOG_EN defined:
  - A WAIT-cycle counter runs in WAIT.
  - If it reaches MUL_LATENCY+4 without mdu_result_vld, pulse mdu_src_clear for one cycle.
  - Go to DONE with wb_data=0.
  - Set err, which stays set until reset.
- SR_MDU_WATCHDOG_EN undefined:
  - No counter.
  - err is tied to 0.
  - WAIT lasts until mdu_result_vld or flush.

## Structure
- Package sr_mdu_pkg holds:
  - opcode constant MDU_OP_MUL = 3'b000;
  - the state enum (IDLE, WAIT, DONE);
  - WDOG_SLACK = 4.
- Sub-module sr_mdu_wdog: a load/clear/expire counter, instantiated only under SR_MDU_WATCHDOG_EN.

## Test plan
- Reset: hold reset_n=0 and drive req_vld=1. Required: stall=0 after the combinational path settles, wb_we=0, err=0, state IDLE.
- MUL with L=2: req_a=7, req_b=6, rd=3, MDU returns 42 at T+3. Required:
  - mdu_src_vld only at T+1;
  - stall high T..T+3;
  - wb_we=1, wb_rd=3, wb_data=42 at T+4 with stall=0.
- Unsupported op 3'b101: Required: no mdu_src_vld; wb_we=1, wb_data=0 at T+1.
- Flush at T+2 during WAIT:
  - Required: mdu_src_clear=1 at T+2, IDLE at T+3.
  - A late mdu_result_vld at T+3 is ignored and produces no wb_we.
- Simultaneous flush and mdu_result_vld: Required: result discarded, no wb_we, IDLE next cycle.
- Watchdog (macro defined), MDU never responds: Required:
  - timeout after MUL_LATENCY+4 = 6 WAIT cycles;
  - mdu_src_clear pulse;
  - wb_data=0 write-back;
  - err stays 1 until reset.

Source files
------------

// File: rtl/sr_mdu_pkg.sv
// Shared constants and state encoding for the MDU issue/stall controller.
package sr_mdu_pkg;

    localparam logic [2:0] MDU_OP_MUL = 3'b000;
    localparam int         WDOG_SLACK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/sr_mdu_wdog.sv
// WAIT-cycle counter: zeroed by load, counts while en, flags expiry on the LIMIT-th counted cycle.
module sr_mdu_wdog #(
    parameter int LIMIT = 6,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = en && (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sr_mdu_issue.sv
// Decode-to-MDU issue/stall controller: launches one op, stalls the core, writes back the result.
// Optional hang watchdog enabled by defining SR_MDU_WATCHDOG_EN.
module sr_mdu_issue
    import sr_mdu_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_vld,
    input  logic [2:0]      req_op,
    input  logic [RD_W-1:0] req_rd,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic            flush,
    output logic            stall,
    output logic [31:0]     mdu_srcA,
    output logic [31:0]     mdu_srcB,
    output logic [2:0]      mdu_op,
    output logic            mdu_src_vld,
    output logic            mdu_src_clear,
    input  logic [31:0]     mdu_result,
    input  logic            mdu_result_vld,
    output logic            wb_we,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            err
);

    mdu_state_e state, state_nxt;
    logic       wd_timeout;

`ifdef SR_MDU_WATCHDOG_EN
    logic wd_expire;

    sr_mdu_wdog #(.LIMIT(MUL_LATENCY + WDOG_SLACK)) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != WAIT),
        .en      (state == WAIT),
        .expire  (wd_expire)
    );

    // A result or flush arriving on the expiry cycle takes precedence.
    assign wd_timeout = wd_expire && !mdu_result_vld && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (wd_timeout)
            err <= 1'b1;
    end
`else
    assign wd_timeout = 1'b0;
    assign err        = 1'b0;
`endif

    // Gated by reset so the core is never frozen while the controller is held in reset.
    assign stall         = reset_n && (((state == IDLE) && req_vld && !flush) || (state == WAIT));
    assign wb_we         = (state == DONE) && !flush;
    assign mdu_src_clear = flush || wd_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_vld) state_nxt = (req_op == MDU_OP_MUL) ? WAIT : DONE;
            WAIT: if (mdu_result_vld || wd_timeout) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdu_srcA    <= '0;
            mdu_srcB    <= '0;
            mdu_op      <= '0;
            mdu_src_vld <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            mdu_src_vld <= 1'b0;
            if (!flush) begin
                unique case (state)
                    IDLE: if (req_vld) begin
                        wb_rd <= req_rd;
                        if (req_op == MDU_OP_MUL) begin
                            mdu_srcA    <= req_a;
                            mdu_srcB    <= req_b;
                            mdu_op      <= req_op;
                            mdu_src_vld <= 1'b1;
                        end else begin
                            wb_data <= '0;
                        end
                    end
                    WAIT: begin
                        if (mdu_result_vld)
                            wb_data <= mdu_result;
                        else if (wd_timeout)
                            wb_data <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
